fpmul_iter: RTL and testbench

FPMUL_ITER -- requirements
Module: fpmul_iter

---
 rtl/fpmul_iter.sv | 241 ++++++++++++++++++++++++
 tb/tb_fpmul_iter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fpmul_iter.sv
// Iterative floating-point multiplier: shift-add mantissa loop, one-step normalise, IEEE-style rounding.
// Define FPMUL_STICKY_FLAGS_EN to add clr_flags and accumulate exception flags across results.

module fpmul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [2:0]           round_mp,
`ifdef FPMUL_STICKY_FLAGS_EN
  input  logic                 clr_flags,
`endif
  output logic                 act,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 ov,
  output logic                 un,
  output logic                 inv,
  output logic                 inexact
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 1;
  localparam int SW1 = SW + 1;
  localparam int PW  = 2 * SW;
  localparam int EW  = EXP_W + 2;
  localparam int CW  = $clog2(SW + 1);
  localparam logic signed [EW-1:0] BIAS  = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic [2:0]            mode_q, mode_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [PW-1:0]         acc_q, acc_d, mcand_q, mcand_d;
  logic [SW-1:0]         mplier_q, mplier_d, man_q, man_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  g_q, g_d, r_q, r_d, s_q, s_d;
  logic [W-1:0]          res_q, res_d, out_q, out_d;
  logic [3:0]            rflags_q, rflags_d, flags_q, flags_d;
  logic                  done_q, done_d;

  logic [EXP_W-1:0]      ea, eb;
  logic [SW-1:0]         ma, mb;
  logic                  sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                  rne, inx, inc, to_inf;
  logic [SW:0]           sum;
  logic [MAN_W-1:0]      mant_r;
  logic signed [EW-1:0]  exp_r;

  // Next-state and datapath: operands are classified in UNPACK, the first multiplier
  // bit is consumed there too, the remaining MAN_W bits in MUL, then NORM/ROUND/DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    man_d    = man_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    res_d    = res_q;
    rflags_d = rflags_q;
    out_d    = out_q;
    done_d   = 1'b0;
`ifdef FPMUL_STICKY_FLAGS_EN
    flags_d  = clr_flags ? 4'b0000 : flags_q;
`else
    flags_d  = flags_q;
`endif

    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    ma     = {1'b1, a_q[MAN_W-1:0]};
    mb     = {1'b1, b_q[MAN_W-1:0]};
    sgn    = a_q[W-1] ^ b_q[W-1];
    a_nan  = (&ea) & (|a_q[MAN_W-1:0]);
    b_nan  = (&eb) & (|b_q[MAN_W-1:0]);
    a_inf  = (&ea) & ~(|a_q[MAN_W-1:0]);
    b_inf  = (&eb) & ~(|b_q[MAN_W-1:0]);
    a_zero = ~(|ea);
    b_zero = ~(|eb);

    rne = mode_q[2] | (mode_q[1:0] == 2'b00);
    inx = g_q | r_q | s_q;
    if (rne)                        inc = g_q & (r_q | s_q | man_q[0]);
    else if (mode_q[1:0] == 2'b10)  inc = inx & ~sgn;
    else if (mode_q[1:0] == 2'b11)  inc = inx & sgn;
    else                            inc = 1'b0;
    to_inf = rne | ((mode_q[1:0] == 2'b10) & ~sgn) | ((mode_q[1:0] == 2'b11) & sgn);
    sum = {1'b0, man_q} + SW1'(inc);
    if (sum[SW]) begin
      mant_r = sum[SW-1:1];
      exp_r  = exp_q + EONE;
    end else begin
      mant_r = sum[MAN_W-1:0];
      exp_r  = exp_q;
    end

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          a_d     = a;
          b_d     = b;
          mode_d  = round_mp;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        state_d = DONE;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
          res_d    = QNAN;
          rflags_d = 4'b0010;
        end else if (a_inf | b_inf) begin
          res_d    = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          rflags_d = 4'b0000;
        end else if (a_zero | b_zero) begin
          res_d    = {sgn, {(W-1){1'b0}}};
          rflags_d = 4'b0000;
        end else begin
          exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
          acc_d    = b_q[0] ? {{(PW-SW){1'b0}}, ma} : '0;
          mcand_d  = {{(PW-SW){1'b0}}, ma} << 1;
          mplier_d = mb >> 1;
          cnt_d    = CW'(1);
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MAN_W)) state_d = NORM;
      end
      NORM: begin
        if (acc_q[PW-1]) begin
          man_d = acc_q[PW-1 -: SW];
          g_d   = acc_q[PW-1-SW];
          r_d   = acc_q[PW-2-SW];
          s_d   = |acc_q[PW-3-SW:0];
          exp_d = exp_q + EONE;
        end else begin
          man_d = acc_q[PW-2 -: SW];
          g_d   = acc_q[PW-2-SW];
          r_d   = acc_q[PW-3-SW];
          s_d   = |acc_q[PW-4-SW:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (exp_r >= EMAX) begin
          res_d    = to_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          rflags_d = 4'b1001;
        end else if (exp_r <= EZERO) begin
          res_d    = {sgn, {(W-1){1'b0}}};
          rflags_d = 4'b0101;
        end else begin
          res_d    = {sgn, exp_r[EXP_W-1:0], mant_r};
          rflags_d = {3'b000, inx};
        end
        state_d = DONE;
      end
      DONE: begin
        out_d   = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef FPMUL_STICKY_FLAGS_EN
        flags_d = flags_d | rflags_q;
`else
        flags_d = rflags_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      exp_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      man_q    <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      res_q    <= '0;
      rflags_q <= '0;
      out_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      res_q    <= res_d;
      rflags_q <= rflags_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // The done cycle still counts as busy, so a start there is ignored.
  assign act  = (state_q != IDLE) | done_q;
  assign done = done_q;
  assign out  = out_q;
  assign {ov, un, inv, inexact} = flags_q;

endmodule

// File: tb/tb_fpmul_iter.sv
// Randomised and directed bench for fpmul_iter against an arithmetic reference model.
// Compile with FPMUL_STICKY_FLAGS_EN to also exercise the sticky-flag build.

module tb_fpmul_iter;

  logic        clk = 1'b0;
  logic        rstp, start;
  logic [31:0] a, b, out;
  logic [2:0]  round_mp;
  logic        act, done, ov, un, inv, inexact;
`ifdef FPMUL_STICKY_FLAGS_EN
  logic        clr_flags;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  stickyExp;
  logic [31:0] specials [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                32'hFF800000, 32'h7FC00001, 32'h00012345};

  always #5 clk = ~clk;

  fpmul_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rstp(rstp), .start(start), .a(a), .b(b), .round_mp(round_mp),
`ifdef FPMUL_STICKY_FLAGS_EN
    .clr_flags(clr_flags),
`endif
    .act(act), .done(done), .out(out),
    .ov(ov), .un(un), .inv(inv), .inexact(inexact)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit isSpecial(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: exact integer product, rounding decided by comparing the remainder with half an ulp.
  function automatic logic [35:0] refMul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    int ex, ey, e, sh;
    logic s;
    bit xz, yz, xi, yi, xn, yn, rne, up, inx, toInf;
    longint unsigned mx, my, p, mant, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return {4'b0010, 32'h7FC00000};
    if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
    if (xz || yz) return {4'b0000, s, 31'h0};
    mx = 64'(x[22:0]) | (64'd1 << 23);
    my = 64'(y[22:0]) | (64'd1 << 23);
    p  = mx * my;
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    mant = p >> sh;
    rem  = p - (mant << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    rne  = m[2] || (m[1:0] == 2'b00);
    if (rne)                  up = (rem > half) || ((rem == half) && mant[0]);
    else if (m[1:0] == 2'b10) up = inx && !s;
    else if (m[1:0] == 2'b11) up = inx && s;
    else                      up = 1'b0;
    if (up) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin mant = mant >> 1; e++; end
    if (e >= 255) begin
      toInf = rne || ((m[1:0] == 2'b10) && !s) || ((m[1:0] == 2'b11) && s);
      return {4'b1001, toInf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
    end
    if (e <= 0) return {4'b0101, s, 31'h0};
    return {3'b000, inx, s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] genOperand();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return specials[$urandom_range(0, 5)];
    if (sel == 1) return $urandom;
    if (sel == 2) return {1'($urandom), ($urandom_range(0, 1) == 1) ? 8'($urandom_range(235, 254)) : 8'($urandom_range(1, 20)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(70, 185)), 23'($urandom)};
  endfunction

  // Called just after a falling edge; start is accepted at the next rising edge (cycle 0).
  task automatic applyStimulus(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [2:0] m, input bit useKat, input logic [31:0] kat);
    logic [35:0] expv;
    logic [3:0]  expFlags;
    int          cyc, expLat;
    bit          seen;
    expv   = refMul(x, y, m);
    expLat = isSpecial(x, y) ? 3 : 28;
`ifdef FPMUL_STICKY_FLAGS_EN
    expFlags  = stickyExp | expv[35:32];
    stickyExp = expFlags;
`else
    expFlags  = expv[35:32];
`endif
    a = x; b = y; round_mp = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; round_mp = 3'($urandom);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput($sformatf("%s_latency", tag), 64'(cyc), 64'(expLat));
    checkOutput($sformatf("%s_out", tag), 64'(out), 64'(expv[31:0]));
    checkOutput($sformatf("%s_flags", tag), 64'({ov, un, inv, inexact}), 64'(expFlags));
    checkOutput($sformatf("%s_act_done", tag), 64'(act), 64'd1);
    if (useKat) checkOutput($sformatf("%s_known", tag), 64'(out), 64'(kat));
    @(negedge clk);
    checkOutput($sformatf("%s_done_pulse", tag), 64'(done), 64'd0);
    checkOutput($sformatf("%s_act_idle", tag), 64'(act), 64'd0);
    checkOutput($sformatf("%s_out_held", tag), 64'(out), 64'(expv[31:0]));
  endtask

  initial begin
    logic [31:0] x, y;
    rstp = 1'b1; start = 1'b0; a = '0; b = '0; round_mp = '0; stickyExp = '0;
`ifdef FPMUL_STICKY_FLAGS_EN
    clr_flags = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_act", 64'(act), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_out", 64'(out), 64'd0);
    checkOutput("rst_flags", 64'({ov, un, inv, inexact}), 64'd0);
    rstp = 1'b0;

    applyStimulus("two_x_three", 32'h40000000, 32'h40400000, 3'b000, 1'b1, 32'h40C00000);
    applyStimulus("inexact_rne", 32'h3F8CCCCD, 32'hBFA66666, 3'b000, 1'b1, 32'hBFB70A3D);
    applyStimulus("zero_x_inf", 32'h00000000, 32'h7F800000, 3'b000, 1'b1, 32'h7FC00000);
    applyStimulus("underflow", 32'h00800000, 32'h3F000000, 3'b000, 1'b1, 32'h00000000);
    applyStimulus("inf_x_neg", 32'h7F800000, 32'hC0000000, 3'b000, 1'b1, 32'hFF800000);
    applyStimulus("ovf_rne", 32'h7F000000, 32'h7F000000, 3'b000, 1'b1, 32'h7F800000);
    applyStimulus("ovf_rtz", 32'h7F000000, 32'h7F000000, 3'b001, 1'b1, 32'h7F7FFFFF);
    applyStimulus("ovf_neg_up", 32'hFF000000, 32'h7F000000, 3'b010, 1'b1, 32'hFF7FFFFF);

`ifdef FPMUL_STICKY_FLAGS_EN
    applyStimulus("sticky_2x3", 32'h40000000, 32'h40400000, 3'b000, 1'b1, 32'h40C00000);
    checkOutput("sticky_ov_held", 64'(ov), 64'd1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    stickyExp = '0;
    checkOutput("sticky_cleared", 64'({ov, un, inv, inexact}), 64'd0);
`endif

    // Reset in cycle 10 of a normal multiply aborts it; the next start must complete normally.
    a = 32'h40000000; b = 32'h40400000; round_mp = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rstp = 1'b1;
    #1;
    checkOutput("midrst_act", 64'(act), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_out", 64'(out), 64'd0);
    checkOutput("midrst_flags", 64'({ov, un, inv, inexact}), 64'd0);
    @(negedge clk);
    rstp = 1'b0;
    stickyExp = '0;
    applyStimulus("after_rst", 32'h3FC00000, 32'h40800000, 3'b000, 1'b1, 32'h40C00000);

    for (int i = 0; i < 40; i++) begin
      x = genOperand();
      y = genOperand();
      applyStimulus($sformatf("rnd%0d", i), x, y, 3'($urandom_range(0, 7)), 1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
